// File: rtl/spi_main_arbiter.sv
// rtl/spi_main_arbiter.sv - SPI main controller sharing one bus among N_REQ requesters
// Round-robin grant, one 8-bit full-duplex transfer per grant, per-subordinate chip selects.
module spi_main_arbiter #(
  parameter int N_REQ   = 4,
  parameter int N_SUB   = 2,
  parameter int CLK_DIV = 4,
  parameter int TW      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*8-1:0]    req_data,
  input  logic [N_REQ*TW-1:0]   req_target,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic [2:0]            rsp_id,
  output logic                  rsp_err,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [N_SUB-1:0]      cs
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam int CW = $clog2(CLK_DIV);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       half;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [2:0]       own_id;
  logic             own_err;
  logic [2:0]       rr;
  logic             sel_found;
  logic [2:0]       sel_idx;
  logic [7:0]       sel_data;
  logic [TW-1:0]    sel_tgt;
  logic [N_SUB-1:0] sel_cs;
  logic             sel_in_range;
  logic [3:0]       scan;
  logic             cnt_done;

  assign cnt_done = (cnt == CW'(CLK_DIV - 1));

  // Scan positions rr, rr+1, ... modulo N_REQ; the first active request wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    scan      = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = 4'(rr) + 4'(k);
      if (scan >= 4'(N_REQ)) scan = scan - 4'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!sel_found && scan == 4'(i) && req[i]) begin
          sel_found = 1'b1;
          sel_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    sel_tgt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_tgt  = req_target[TW*i +: TW];
      end
    end
    sel_in_range = (int'(sel_tgt) < N_SUB);
    sel_cs = '1;
    for (int i = 0; i < N_SUB; i++) begin
      if (int'(sel_tgt) == i) sel_cs[i] = 1'b0;
    end
  end

  // The grant cycle is the IDLE cycle itself, so busy drops for the GAP cycle only.
  assign grant = (!reset && state == S_IDLE && sel_found)
               ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign busy  = !reset && ((state == S_SETUP) || (state == S_SHIFT) ||
                            (state == S_HOLD)  || (state == S_DONE)  ||
                            (state == S_IDLE && sel_found));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      half      <= 4'd0;
      tx_sr     <= 8'h00;
      rx_sr     <= 8'h00;
      own_id    <= 3'd0;
      own_err   <= 1'b0;
      rr        <= 3'd0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs        <= '1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= 3'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            tx_sr   <= sel_data;
            mosi    <= sel_data[7];
            cs      <= sel_cs;
            own_err <= !sel_in_range;
            own_id  <= sel_idx;
            rr      <= (sel_idx == 3'(N_REQ - 1)) ? 3'd0 : sel_idx + 3'd1;
            cnt     <= '0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_done) begin
            cnt   <= '0;
            half  <= 4'd0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_done) begin
            cnt  <= '0;
            half <= half + 4'd1;
            if (!half[0]) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              sclk  <= 1'b0;
              tx_sr <= {tx_sr[6:0], 1'b0};
              mosi  <= tx_sr[6];
              if (half == 4'd15) state <= S_HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_done) begin
            cnt       <= '0;
            cs        <= '1;
            rsp_valid <= 1'b1;
            rsp_data  <= own_err ? 8'h00 : rx_sr;
            rsp_id    <= own_id;
            rsp_err   <= own_err;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_main_arbiter.sv
// tb/tb_spi_main_arbiter.sv - directed bench with a cycle-offset model of the SPI arbiter
module tb_spi_main_arbiter;
  localparam int N_REQ = 4;
  localparam int N_SUB = 2;
  localparam int CLK_DIV = 4;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ*8-1:0] req_data = '0;
  logic [N_REQ*TW-1:0] req_target = '0;
  logic [N_REQ-1:0] grant;
  logic busy, rsp_valid, rsp_err, sclk, mosi, miso;
  logic [7:0] rsp_data;
  logic [2:0] rsp_id;
  logic [N_SUB-1:0] cs;

  logic loopback = 1'b1;
  logic [7:0] sub_sr = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  int cyc = 0;
  int total = 0;
  int passed = 0;

  spi_main_arbiter #(.N_REQ(N_REQ), .N_SUB(N_SUB), .CLK_DIV(CLK_DIV), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_target(req_target),
    .grant(grant), .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 subordinate: presents MSB when selected, advances on each falling sclk.
  assign miso = loopback ? mosi : sub_sr[7];
  initial forever begin
    @(negedge sclk);
    sub_sr = {sub_sr[6:0], 1'b0};
  end
  initial forever begin
    @(posedge sclk);
    mosi_cap = {mosi_cap[6:0], mosi};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else
      passed++;
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: no event within cycle budget (cycle %0d)", nm, cyc);
  endtask

  // Model: every output is a function of the cycle offset from the grant.
  int t0 = 0, m_id = 0, m_rr = 0, off = 0, find = -1, bitn = 0;
  logic m_active = 1'b0, rst_d = 1'b0;
  logic [7:0] m_data = 8'h00, m_rx = 8'h00, m_rsp_data = 8'h00;
  logic [2:0] m_rsp_id = 3'd0;
  logic [TW-1:0] m_tgt = '0;
  logic [N_SUB-1:0] ecs;
  logic [N_REQ-1:0] egrant;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (rst_d) begin
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cs", 32'(cs), 32'(2'b11));
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
      end
      m_active = 1'b0;
      m_rr = 0;
      m_rsp_data = 8'h00;
      m_rsp_id = 3'd0;
    end else begin
      off = cyc - t0;
      if (!m_active || off >= 75) begin
        m_active = 1'b0;
        find = -1;
        for (int k = 0; k < N_REQ; k++)
          if (find < 0 && req[(m_rr + k) % N_REQ]) find = (m_rr + k) % N_REQ;
        egrant = (find >= 0) ? N_REQ'(1 << find) : '0;
        chk("grant", 32'(grant), 32'(egrant));
        chk("busy_idle", 32'(busy), 32'(find >= 0));
        chk("cs_idle", 32'(cs), 32'(2'b11));
        chk("sclk_idle", 32'(sclk), 0);
        chk("rsp_valid_idle", 32'(rsp_valid), 0);
        if (find >= 0) begin
          m_active = 1'b1;
          t0 = cyc;
          m_id = find;
          m_data = req_data[find*8 +: 8];
          m_tgt = req_target[find*TW +: TW];
          m_rx = loopback ? m_data : sub_sr;
          m_rr = (find + 1) % N_REQ;
        end
      end else begin
        ecs = '1;
        if (off >= 1 && off <= 72 && int'(m_tgt) < N_SUB) ecs[m_tgt] = 1'b0;
        chk("grant_busy", 32'(grant), 0);
        chk("busy", 32'(busy), 32'(off <= 73));
        chk("cs", 32'(cs), 32'(ecs));
        chk("sclk", 32'(sclk), 32'(off >= 5 && off <= 68 && ((off - 5) / 4) % 2 == 1));
        if (off >= 1 && off <= 68) begin
          bitn = (off <= 12) ? 7 : 7 - (off - 5) / 8;
          chk("mosi", 32'(mosi), 32'(m_data[bitn]));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(off == 73));
        if (off == 73) begin
          m_rsp_data = (int'(m_tgt) < N_SUB) ? m_rx : 8'h00;
          m_rsp_id = 3'(m_id);
          chk("rsp_err", 32'(rsp_err), 32'(int'(m_tgt) >= N_SUB));
        end
      end
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    end
    rst_d = reset;
  end

  task automatic wait_grant(output int idx, output int gcyc);
    logic seen;
    seen = 1'b0;
    idx = -1;
    gcyc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (grant != '0) begin
        seen = 1'b1;
        gcyc = cyc;
        for (int i = 0; i < N_REQ; i++) if (grant[i]) idx = i;
      end
    end
    if (!seen) timeout("wait_grant");
  endtask

  task automatic wait_rsp(output int rcyc);
    logic seen;
    seen = 1'b0;
    rcyc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        rcyc = cyc;
      end
    end
    if (!seen) timeout("wait_rsp");
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int gi, gc, rc;
  int gidx[5];
  int gcy[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("init_busy", 32'(busy), 0);
    chk("init_cs", 32'(cs), 32'(2'b11));
    step();
    reset = 1'b0;

    // Single loopback transfer to subordinate 0.
    req_data[7:0] = 8'hA5;
    req_target[2:0] = 3'd0;
    req[0] = 1'b1;
    wait_grant(gi, gc);
    chk("t1_grant_idx", 32'(gi), 0);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_cs", 32'(cs), 32'(2'b10));
    wait_rsp(rc);
    chk("t1_latency", 32'(rc - gc), 73);
    chk("t1_rsp_data", 32'(rsp_data), 32'(8'hA5));
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_mosi_bits", 32'(mosi_cap), 32'(8'hA5));
    chk("t1_cs_released", 32'(cs), 32'(2'b11));

    // Fixed miso pattern from subordinate 1.
    step();
    loopback = 1'b0;
    sub_sr = 8'h3C;
    req_data[15:8] = 8'h5A;
    req_target[5:3] = 3'd1;
    req[1] = 1'b1;
    wait_grant(gi, gc);
    chk("t2_grant_idx", 32'(gi), 1);
    step();
    req[1] = 1'b0;
    @(negedge clk);
    chk("t2_cs", 32'(cs), 32'(2'b01));
    wait_rsp(rc);
    chk("t2_rsp_data", 32'(rsp_data), 32'(8'h3C));
    chk("t2_rsp_id", 32'(rsp_id), 1);
    chk("t2_mosi_bits", 32'(mosi_cap), 32'(8'h5A));
    chk("t2_cs_released", 32'(cs), 32'(2'b11));

    // All requesters held: round robin from a fresh pointer.
    step();
    loopback = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_target = '0;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gidx[k], gcy[k]);
      chk("t3_order", 32'(gidx[k]), 32'(exp_order[k]));
      if (k > 0) chk("t3_spacing", 32'(gcy[k] - gcy[k-1]), 75);
    end
    step();
    req = '0;
    wait_rsp(rc);
    chk("t3_last_rsp", 32'(rsp_data), 32'(8'h11));

    // Out-of-range target.
    step();
    req_data[23:16] = 8'hC3;
    req_target[8:6] = 3'd5;
    req[2] = 1'b1;
    wait_grant(gi, gc);
    chk("t4_grant_idx", 32'(gi), 2);
    step();
    req[2] = 1'b0;
    @(negedge clk);
    chk("t4_cs", 32'(cs), 32'(2'b11));
    wait_rsp(rc);
    chk("t4_latency", 32'(rc - gc), 73);
    chk("t4_rsp_err", 32'(rsp_err), 1);
    chk("t4_rsp_data", 32'(rsp_data), 0);
    chk("t4_rsp_id", 32'(rsp_id), 2);

    // Reset in the middle of SHIFT.
    step();
    req_data[15:8] = 8'h77;
    req_target[5:3] = 3'd0;
    req[1] = 1'b1;
    wait_grant(gi, gc);
    step();
    req[1] = 1'b0;
    repeat (30) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t5_sclk", 32'(sclk), 0);
    chk("t5_cs", 32'(cs), 32'(2'b11));
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    step();
    req = 4'b1011;
    step();
    reset = 1'b0;
    wait_grant(gi, gc);
    chk("t5_grant_after_reset", 32'(gi), 0);
    step();
    req = '0;
    wait_rsp(rc);
    chk("t5_rsp_id", 32'(rsp_id), 0);

    // Request data changes right after grant.
    step();
    req_data[7:0] = 8'h11;
    req_target[2:0] = 3'd0;
    req[0] = 1'b1;
    wait_grant(gi, gc);
    step();
    req[0] = 1'b0;
    req_data[7:0] = 8'hFF;
    wait_rsp(rc);
    chk("t6_mosi_bits", 32'(mosi_cap), 32'(8'h11));
    chk("t6_rsp_data", 32'(rsp_data), 32'(8'h11));
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
